trap_controller: RTL and testbench

Machine-mode trap sequencer for the RV32 core. It consumes the decoded `o_exception` / `o_causeNum` / `o_mret` signals from the exception decoder and the platform interrupt lines, and arbitrates between them at instruction boundaries. It owns the trap CSRs and drives a stall/flush/redirect sequence to fetch. It sits between decode/execute and the PC-select logic and replaces any ad-hoc trap handling in the datapath.

---
 rtl/trap_controller.sv | 208 ++++++++++++++++++++
 tb/tb_trap_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap sequencer for the RV32 core.
// Arbitrates exceptions, interrupts and mret at instruction boundaries, owns
// the machine trap CSRs and drives the stall/flush/redirect sequence to fetch.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid, i_pc         instruction boundary strobe and its PC
//   i_exception,
//   i_causeNum, i_mret    decoded trap/return events
//   i_timerIrq, i_swIrq,
//   i_extIrq              level interrupt lines (mip bits 7, 3, 11)
//   i_csrWe, i_csrAddr,
//   i_csrWdata            CSR write port
//   o_csrRdata            combinational read of i_csrAddr
//   o_stall, o_flush,
//   o_redirect,
//   o_redirectPc          registered control to fetch / PC select
//
// Optional build macro: TRAP_VECTORED_EN enables vectored interrupt mode
// (mtvec[1:0] = 01 sends interrupts to base + 4*code).
module trap_controller #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic        i_exception,
  input  logic [3:0]  i_causeNum,
  input  logic        i_mret,
  input  logic        i_timerIrq,
  input  logic        i_swIrq,
  input  logic        i_extIrq,
  input  logic        i_csrWe,
  input  logic [11:0] i_csrAddr,
  input  logic [31:0] i_csrWdata,
  output logic [31:0] o_csrRdata,
  output logic        o_stall,
  output logic        o_flush,
  output logic        o_redirect,
  output logic [31:0] o_redirectPc
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [31:0] MIE_MASK      = 32'h0000_0888;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SAVE      = 2'd1,
    ST_TRAP_JUMP = 2'd2,
    ST_MRET_JUMP = 2'd3
  } state_e;

  state_e      state_q;
  logic        mstatus_mie_q;
  logic        mstatus_mpie_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] pc_lat_q;
  logic [31:0] cause_lat_q;

  logic [31:0] mip;
  logic [31:0] irq_active;
  logic        irq_pending;
  logic [4:0]  irq_code;
  logic        in_idle;
  logic        trap_accept;
  logic        mret_accept;
  logic        csr_wr_en;
  logic [31:0] trap_target_d;

  // Keep only legal mtvec mode encodings.
  function automatic logic [31:0] legal_mtvec(input logic [31:0] v);
`ifdef TRAP_VECTORED_EN
    return {v[31:2], (v[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
    return {v[31:2], 2'b00};
`endif
  endfunction

  assign mip = {20'b0, i_extIrq, 3'b0, i_timerIrq, 3'b0, i_swIrq, 3'b0};
  assign irq_active  = mip & mie_q;
  assign irq_pending = mstatus_mie_q & (|irq_active);

  // Interrupt priority: external, then software, then timer.
  always_comb begin
    irq_code = 5'd7;
    if (irq_active[11])     irq_code = 5'd11;
    else if (irq_active[3]) irq_code = 5'd3;
  end

  assign in_idle     = (state_q == ST_IDLE);
  assign trap_accept = in_idle & i_valid & (i_exception | irq_pending);
  assign mret_accept = in_idle & i_valid & ~trap_accept & i_mret;
  // The trapping instruction never commits its CSR write.
  assign csr_wr_en   = in_idle & i_csrWe & ~trap_accept;

  // Trap vector, evaluated in SAVE from the latched cause.
  always_comb begin
    trap_target_d = {mtvec_q[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (cause_lat_q[31] && (mtvec_q[1:0] == 2'b01)) begin
      trap_target_d = {mtvec_q[31:2], 2'b00} + {25'b0, cause_lat_q[4:0], 2'b00};
    end
`endif
  end

  // CSR read mux.
  always_comb begin
    o_csrRdata = 32'h0;
    case (i_csrAddr)
      ADDR_MSTATUS:  o_csrRdata = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      ADDR_MIE:      o_csrRdata = mie_q;
      ADDR_MTVEC:    o_csrRdata = mtvec_q;
      ADDR_MSCRATCH: o_csrRdata = mscratch_q;
      ADDR_MEPC:     o_csrRdata = mepc_q;
      ADDR_MCAUSE:   o_csrRdata = mcause_q;
      ADDR_MIP:      o_csrRdata = mip;
      default:       o_csrRdata = 32'h0;
    endcase
  end

  // Sequencer, CSR state and registered fetch controls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'h0;
      mtvec_q        <= legal_mtvec(MTVEC_RESET);
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      pc_lat_q       <= 32'h0;
      cause_lat_q    <= 32'h0;
      o_stall        <= 1'b0;
      o_flush        <= 1'b0;
      o_redirect     <= 1'b0;
      o_redirectPc   <= 32'h0;
    end else begin
      o_stall      <= 1'b0;
      o_flush      <= 1'b0;
      o_redirect   <= 1'b0;
      o_redirectPc <= 32'h0;
      case (state_q)
        ST_IDLE: begin
          if (trap_accept) begin
            state_q     <= ST_SAVE;
            pc_lat_q    <= i_pc;
            cause_lat_q <= i_exception ? {28'b0, i_causeNum}
                                       : {1'b1, 26'b0, irq_code};
            o_stall     <= 1'b1;
            o_flush     <= 1'b1;
          end else if (mret_accept) begin
            state_q      <= ST_MRET_JUMP;
            o_stall      <= 1'b1;
            o_flush      <= 1'b1;
            o_redirect   <= 1'b1;
            o_redirectPc <= mepc_q;
          end
          if (csr_wr_en) begin
            case (i_csrAddr)
              ADDR_MSTATUS: begin
                mstatus_mie_q  <= i_csrWdata[3];
                mstatus_mpie_q <= i_csrWdata[7];
              end
              ADDR_MIE:      mie_q      <= i_csrWdata & MIE_MASK;
              ADDR_MTVEC:    mtvec_q    <= legal_mtvec(i_csrWdata);
              ADDR_MSCRATCH: mscratch_q <= i_csrWdata;
              ADDR_MEPC:     mepc_q     <= {i_csrWdata[31:2], 2'b00};
              ADDR_MCAUSE:   mcause_q   <= i_csrWdata;
              default: ;
            endcase
          end
        end
        ST_SAVE: begin
          state_q        <= ST_TRAP_JUMP;
          mepc_q         <= {pc_lat_q[31:2], 2'b00};
          mcause_q       <= cause_lat_q;
          mstatus_mpie_q <= mstatus_mie_q;
          mstatus_mie_q  <= 1'b0;
          o_stall        <= 1'b1;
          o_redirect     <= 1'b1;
          o_redirectPc   <= trap_target_d;
        end
        ST_TRAP_JUMP: begin
          state_q <= ST_IDLE;
        end
        ST_MRET_JUMP: begin
          state_q        <= ST_IDLE;
          mstatus_mie_q  <= mstatus_mpie_q;
          mstatus_mpie_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed self-checking bench for trap_controller.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        exc = 1'b0;
  logic [3:0]  cause = 4'h0;
  logic        mret = 1'b0;
  logic        tirq = 1'b0;
  logic        sirq = 1'b0;
  logic        eirq = 1'b0;
  logic        we = 1'b0;
  logic [11:0] addr = 12'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall;
  logic        flush;
  logic        redir;
  logic [31:0] redir_pc;

  int tests = 0;
  int errors = 0;

  trap_controller #(.MTVEC_RESET(32'h0000_0000)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .i_pc         (pc),
    .i_exception  (exc),
    .i_causeNum   (cause),
    .i_mret       (mret),
    .i_timerIrq   (tirq),
    .i_swIrq      (sirq),
    .i_extIrq     (eirq),
    .i_csrWe      (we),
    .i_csrAddr    (addr),
    .i_csrWdata   (wdata),
    .o_csrRdata   (rdata),
    .o_stall      (stall),
    .o_flush      (flush),
    .o_redirect   (redir),
    .o_redirectPc (redir_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic s, input logic f,
                      input logic r, input logic [31:0] p);
    chk({tag, ".stall"}, 32'(stall), 32'(s));
    chk({tag, ".flush"}, 32'(flush), 32'(f));
    chk({tag, ".redirect"}, 32'(redir), 32'(r));
    chk({tag, ".pc"}, redir_pc, p);
  endtask

  // Reads are only done with i_valid and i_csrWe low.
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    addr = a;
    @(negedge clk);
    chk(tag, rdata, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    // Reset
    tick(); tick();
    rst = 1'b0;
    tick();
    outs("reset", 1'b0, 1'b0, 1'b0, 32'h0);
    rd("reset.mtvec", 12'h305, 32'h0);
    rd("reset.mstatus", 12'h300, 32'h0);

    // ecall to mtvec base
    wr(12'h305, 32'h100);
    valid = 1'b1; pc = 32'h40; exc = 1'b1; cause = 4'd8;
    tick();
    valid = 1'b0; exc = 1'b0;
    outs("ecall.save", 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    outs("ecall.jump", 1'b1, 1'b0, 1'b1, 32'h100);
    tick();
    outs("ecall.idle", 1'b0, 1'b0, 1'b0, 32'h0);
    rd("ecall.mepc", 12'h341, 32'h40);
    rd("ecall.mcause", 12'h342, 32'h8);
    rd("ecall.mstatus", 12'h300, 32'h0);

    // Timer interrupt
    wr(12'h300, 32'h8);
    wr(12'h304, 32'h80);
    tirq = 1'b1;
    rd("irq.mip", 12'h344, 32'h80);
    rd("irq.mie", 12'h304, 32'h80);
    valid = 1'b1; pc = 32'h80;
    tick();
    valid = 1'b0;
    outs("irq.save", 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    outs("irq.jump", 1'b1, 1'b0, 1'b1, 32'h100);
    tirq = 1'b0;
    tick();
    rd("irq.mcause", 12'h342, 32'h8000_0007);
    rd("irq.mepc", 12'h341, 32'h80);
    rd("irq.mstatus", 12'h300, 32'h80);

    // mret back to mepc
    valid = 1'b1; mret = 1'b1;
    tick();
    valid = 1'b0; mret = 1'b0;
    outs("mret.jump", 1'b1, 1'b1, 1'b1, 32'h80);
    tick();
    outs("mret.idle", 1'b0, 1'b0, 1'b0, 32'h0);
    rd("mret.mstatus", 12'h300, 32'h88);

    // External beats timer
    wr(12'h304, 32'h880);
    eirq = 1'b1; tirq = 1'b1;
    valid = 1'b1; pc = 32'h90;
    tick();
    valid = 1'b0;
    tick(); tick();
    eirq = 1'b0; tirq = 1'b0;
    rd("prio.ext.mcause", 12'h342, 32'h8000_000B);

    // Exception beats pending interrupt and a simultaneous mret
    wr(12'h300, 32'h8);
    tirq = 1'b1;
    valid = 1'b1; exc = 1'b1; cause = 4'd2; mret = 1'b1; pc = 32'h94;
    tick();
    valid = 1'b0; exc = 1'b0; mret = 1'b0;
    outs("prio.exc.save", 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    outs("prio.exc.jump", 1'b1, 1'b0, 1'b1, 32'h100);
    tick();
    tirq = 1'b0;
    rd("prio.exc.mcause", 12'h342, 32'h2);
    rd("prio.exc.mepc", 12'h341, 32'h94);

    // CSR write dropped in accept cycle and in SAVE
    valid = 1'b1; exc = 1'b1; cause = 4'd8; pc = 32'h98;
    we = 1'b1; addr = 12'h340; wdata = 32'h1234;
    tick();
    valid = 1'b0; exc = 1'b0;
    tick();
    we = 1'b0;
    tick();
    rd("block.mscratch", 12'h340, 32'h0);
    wr(12'h340, 32'h55);
    rd("write.mscratch", 12'h340, 32'h55);

    // CSR field behaviour
    wr(12'h341, 32'h123);
    rd("mepc.align", 12'h341, 32'h120);
    wr(12'h7C0, 32'hFFFF);
    rd("unmapped", 12'h7C0, 32'h0);
    wr(12'h344, 32'hFFFF);
    rd("mip.ro", 12'h344, 32'h0);
    wr(12'h305, 32'h201);
`ifdef TRAP_VECTORED_EN
    rd("mtvec.mode", 12'h305, 32'h201);
`else
    rd("mtvec.mode", 12'h305, 32'h200);
`endif

    // Reset in SAVE
    valid = 1'b1; exc = 1'b1; cause = 4'd2; pc = 32'hC0;
    tick();
    valid = 1'b0; exc = 1'b0;
    outs("rst.pre", 1'b1, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    outs("rst.idle", 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    tick();
    outs("rst.after", 1'b0, 1'b0, 1'b0, 32'h0);
    rd("rst.mepc", 12'h341, 32'h0);
    rd("rst.mtvec", 12'h305, 32'h0);
    rd("rst.mcause", 12'h342, 32'h0);
    rd("rst.mstatus", 12'h300, 32'h0);
    rd("rst.mie", 12'h304, 32'h0);
    rd("rst.mscratch", 12'h340, 32'h0);

    // Interrupt held off by MIE=0, taken once MIE is set
    wr(12'h304, 32'h80);
    tirq = 1'b1;
    valid = 1'b1; pc = 32'hA0;
    tick();
    valid = 1'b0;
    chk("masked.stall", 32'(stall), 32'h0);
    wr(12'h300, 32'h8);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    outs("unmasked.save", 1'b1, 1'b1, 1'b0, 32'h0);
    tick(); tick();
    tirq = 1'b0;
    rd("unmasked.mcause", 12'h342, 32'h8000_0007);
    rd("unmasked.mepc", 12'h341, 32'hA0);

`ifdef TRAP_VECTORED_EN
    // Vectored interrupt, exception to base
    wr(12'h305, 32'h201);
    wr(12'h304, 32'h8);
    wr(12'h300, 32'h8);
    sirq = 1'b1;
    valid = 1'b1; pc = 32'hB0;
    tick();
    valid = 1'b0;
    tick();
    outs("vec.irq.jump", 1'b1, 1'b0, 1'b1, 32'h20C);
    tick();
    sirq = 1'b0;
    valid = 1'b1; exc = 1'b1; cause = 4'd8;
    tick();
    valid = 1'b0; exc = 1'b0;
    tick();
    outs("vec.exc.jump", 1'b1, 1'b0, 1'b1, 32'h200);
    tick();
    wr(12'h305, 32'h203);
    rd("vec.mtvec.illegal", 12'h305, 32'h200);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
